// File: rtl/water_distribution_controller.sv
// water_distribution_controller: splits reservoir water between city and town, proportionally on shortage.
// A sequential shift-add multiplier and a restoring divider compute the city share; the total is drawn over valid/ready.
module water_distribution_controller #(
    parameter int LEVEL_W = 10,
    parameter int POP_W   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEVEL_W-1:0] reservoir_level,
    input  logic [POP_W-1:0]   city_population,
    input  logic [POP_W-1:0]   town_population,
    input  logic               draw_ready,
    output logic               draw_valid,
    output logic [LEVEL_W-1:0] draw_amount,
    output logic [LEVEL_W-1:0] city_alloc,
    output logic [LEVEL_W-1:0] town_alloc,
    output logic               shortage,
    output logic               busy,
    output logic               done
);
    localparam int PW = LEVEL_W + POP_W;
    localparam int CW = $clog2(PW);

    typedef enum logic [2:0] {IDLE, CALC, MULT, DIV, SPLIT, DRAW, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d, dem_q, dem_d, rem_q, rem_d;
    logic [LEVEL_W-1:0] city_q, city_d, town_q, town_d;
    logic [POP_W-1:0]   cpop_q, cpop_d, tpop_q, tpop_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               short_q, short_d;
    logic [LEVEL_W-1:0] sum;
    logic [LEVEL_W:0]   part;
    logic               ge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            level_q <= '0;
            dem_q   <= '0;
            rem_q   <= '0;
            city_q  <= '0;
            town_q  <= '0;
            cpop_q  <= '0;
            tpop_q  <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            dem_q   <= dem_d;
            rem_q   <= rem_d;
            city_q  <= city_d;
            town_q  <= town_d;
            cpop_q  <= cpop_d;
            tpop_q  <= tpop_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
        end
    end

    // Restoring-divide step: bring down the next dividend bit, subtract the demand if it fits
    assign part = {rem_q, prod_q[PW-1]};
    assign ge   = part >= {1'b0, dem_q};
    assign sum  = LEVEL_W'(cpop_q) + LEVEL_W'(tpop_q);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dem_d   = dem_q;
        rem_d   = rem_q;
        city_d  = city_q;
        town_d  = town_q;
        cpop_d  = cpop_q;
        tpop_d  = tpop_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        short_d = short_q;
        case (state_q)
            IDLE: if (start) begin
                level_d = reservoir_level;
                cpop_d  = city_population;
                tpop_d  = town_population;
                short_d = 1'b0;
                state_d = CALC;
            end
            CALC: begin
                dem_d  = sum;
                prod_d = '0;
                rem_d  = '0;
                cnt_d  = '0;
                city_d = sum == '0 ? '0 : LEVEL_W'(cpop_q);
                town_d = sum == '0 ? '0 : LEVEL_W'(tpop_q);
                short_d = sum > level_q;
                state_d = sum == '0 ? DONE : sum > level_q ? MULT : DRAW;
            end
            MULT: begin
                prod_d  = prod_q + (cpop_q[0] ? PW'(level_q) << cnt_q : '0);
                cpop_d  = cpop_q >> 1;
                cnt_d   = cnt_q == CW'(POP_W - 1) ? '0 : cnt_q + 1'b1;
                state_d = cnt_q == CW'(POP_W - 1) ? DIV : MULT;
            end
            DIV: begin
                rem_d   = ge ? LEVEL_W'(part - {1'b0, dem_q}) : part[LEVEL_W-1:0];
                prod_d  = {prod_q[PW-2:0], ge};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(PW - 1) ? SPLIT : DIV;
            end
            SPLIT: begin
                city_d  = prod_q[LEVEL_W-1:0];
                town_d  = level_q - prod_q[LEVEL_W-1:0];
                state_d = DRAW;
            end
            DRAW:    state_d = draw_ready ? DONE : DRAW;
            default: state_d = IDLE;
        endcase
    end

    assign draw_valid  = state_q == DRAW;
    assign draw_amount = draw_valid ? city_q + town_q : '0;
    assign city_alloc  = city_q;
    assign town_alloc  = town_q;
    assign shortage    = short_q;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
endmodule

// File: tb/tb_water_distribution_controller.sv
// tb_water_distribution_controller: directed scenario tasks with hand-computed expectations.
module tb_water_distribution_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] reservoir_level = '0;
    logic [8:0] city_population = '0;
    logic [8:0] town_population = '0;
    logic       draw_ready = 1'b0;
    logic       draw_valid, shortage, busy, done;
    logic [9:0] draw_amount, city_alloc, town_alloc;
    int errors = 0;
    int checks = 0;

    water_distribution_controller dut (
        .clk(clk), .reset(reset), .start(start),
        .reservoir_level(reservoir_level), .city_population(city_population),
        .town_population(town_population), .draw_ready(draw_ready),
        .draw_valid(draw_valid), .draw_amount(draw_amount),
        .city_alloc(city_alloc), .town_alloc(town_alloc),
        .shortage(shortage), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int l, input int c, input int t);
        reservoir_level = 10'(l);
        city_population = 9'(c);
        town_population = 9'(t);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({draw_valid, busy, done, shortage} !== 4'b0 || draw_amount !== 0 || city_alloc !== 0 || town_alloc !== 0) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b done=%b short=%b amt=%0d city=%0d town=%0d, required all 0",
                     draw_valid, busy, done, shortage, draw_amount, city_alloc, town_alloc);
        end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        draw_ready = 1'b1;
        launch(500, 50, 30);
        checks++;
        if (busy !== 1'b1 || draw_valid !== 1'b0) begin
            errors++;
            $display("FAIL normal_calc: busy=%b valid=%b, required 1 0", busy, draw_valid);
        end
        tick();
        checks++;
        if (draw_valid !== 1'b1 || draw_amount !== 80 || city_alloc !== 50 || town_alloc !== 30 || shortage !== 1'b0) begin
            errors++;
            $display("FAIL normal_draw: valid=%b amt=%0d city=%0d town=%0d short=%b, required 1 80 50 30 0",
                     draw_valid, draw_amount, city_alloc, town_alloc, shortage);
        end
        tick();
        checks++;
        if (done !== 1'b1 || draw_valid !== 1'b0 || draw_amount !== 0) begin
            errors++;
            $display("FAIL normal_done: done=%b valid=%b amt=%0d, required 1 0 0", done, draw_valid, draw_amount);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || city_alloc !== 50 || town_alloc !== 30) begin
            errors++;
            $display("FAIL normal_idle: done=%b busy=%b city=%0d town=%0d, required 0 0 50 30", done, busy, city_alloc, town_alloc);
        end
    endtask

    task automatic test_shortage(input string nm, input int l, input int c, input int t, input int ec, input int et);
        int early = 0;
        draw_ready = 1'b1;
        launch(l, c, t);
        for (int i = 1; i <= 29; i++) begin
            tick();
            if (draw_valid) early++;
        end
        checks++;
        if (early != 0 || shortage !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: early_valid_cycles=%0d short=%b, required 0 1", nm, early, shortage);
        end
        tick();
        checks++;
        if (draw_valid !== 1'b1 || draw_amount !== 10'(l) || city_alloc !== 10'(ec) || town_alloc !== 10'(et)) begin
            errors++;
            $display("FAIL %s_alloc: valid=%b amt=%0d city=%0d town=%0d, required 1 %0d %0d %0d",
                     nm, draw_valid, draw_amount, city_alloc, town_alloc, l, ec, et);
        end
        tick();
        checks++;
        if (done !== 1'b1 || shortage !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b short=%b, required 1 1", nm, done, shortage);
        end
        tick();
    endtask

    task automatic test_zero_demand();
        int seen = 0;
        draw_ready = 1'b1;
        launch(700, 0, 0);
        if (draw_valid) seen++;
        tick();
        if (draw_valid) seen++;
        checks++;
        if (done !== 1'b1 || city_alloc !== 0 || town_alloc !== 0 || shortage !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b city=%0d town=%0d short=%b, required 1 0 0 0", done, city_alloc, town_alloc, shortage);
        end
        tick();
        if (draw_valid) seen++;
        checks++;
        if (seen != 0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_nodraw: valid_cycles=%0d busy=%b done=%b, required 0 0 0", seen, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int dones = 0;
        draw_ready = 1'b0;
        launch(500, 10, 20);
        tick();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            if (i == 2) begin
                reservoir_level = 10'd5;
                city_population = 9'd400;
                town_population = 9'd400;
            end
            tick();
            if (draw_valid !== 1'b1 || draw_amount !== 30 || done !== 1'b0) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0 || city_alloc !== 10 || town_alloc !== 20) begin
            errors++;
            $display("FAIL backpressure_hold: bad_cycles=%0d city=%0d town=%0d, required 0 10 20", bad, city_alloc, town_alloc);
        end
        draw_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dones != 1 || busy !== 1'b0 || shortage !== 1'b0 || city_alloc !== 10) begin
            errors++;
            $display("FAIL backpressure_release: done_pulses=%0d busy=%b short=%b city=%0d, required 1 0 0 10",
                     dones, busy, shortage, city_alloc);
        end
    endtask

    task automatic test_async_reset();
        int dones = 0;
        draw_ready = 1'b1;
        launch(400, 300, 200);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (busy !== 1'b1 || shortage !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: busy=%b short=%b, required 1 1", busy, shortage);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({draw_valid, busy, done, shortage} !== 4'b0 || city_alloc !== 0 || town_alloc !== 0) begin
            errors++;
            $display("FAIL areset_now: valid=%b busy=%b done=%b short=%b city=%0d town=%0d, required all 0",
                     draw_valid, busy, done, shortage, city_alloc, town_alloc);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL areset_abort: active_cycles=%0d, required 0", dones);
        end
        launch(500, 50, 30);
        tick();
        checks++;
        if (draw_valid !== 1'b1 || draw_amount !== 80) begin
            errors++;
            $display("FAIL areset_restart_draw: valid=%b amt=%0d, required 1 80", draw_valid, draw_amount);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL areset_restart_done: done=%b, required 1", done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_shortage("shortage", 400, 300, 200, 240, 160);
        test_shortage("trunc", 100, 511, 1, 99, 1);
        test_zero_demand();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/water_distribution_controller.md
Name: water_distribution_controller

Overview:
Consumer-side counterpart of the reservoir/population tracker. On each `start` pulse it snapshots reservoir level and city/town populations, then computes per-region water allocations. When demand exceeds supply it splits the available level in proportion to population, using a sequential shift-add multiplier and a restoring divider. It then draws the total allocation from the reservoir over a valid/ready handshake.

Parameters:
- LEVEL_W, 10, width of reservoir level and allocations
- POP_W, 9, width of population inputs

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to run a distribution cycle; honoured only in IDLE
- reservoir_level  input  10  current reservoir level
- city_population  input  9  city population (units of demand)
- town_population  input  9  town population
- draw_ready  input  1  reservoir accepts the draw this cycle
- draw_valid  output  1  draw request pending
- draw_amount  output  10  water to remove; stable while draw_valid
- city_alloc  output  10  city allocation of the last completed cycle
- town_alloc  output  10  town allocation of the last completed cycle
- shortage  output  1  demand exceeded level in the current/last cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on cycle completion

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs and internal registers become 0.
  - Reset mid-operation aborts the cycle; no done pulse.
- States: IDLE, CALC, MULT, DIV, SPLIT, DRAW, DONE.
- IDLE:
  - On an edge with start=1, latch L=reservoir_level, C=city_population, T=town_population.
  - Clear shortage, go to CALC.
  - start is ignored whenever busy=1.
- CALC (1 cycle): D=C+T, 10-bit, no overflow possible.
  - D==0: city_alloc=town_alloc=0, go to DONE. No draw occurs.
  - D<=L: city_alloc=C, town_alloc=T, go to DRAW.
  - D>L: shortage=1, go to MULT.
- MULT (exactly 9 cycles):
  - Shift-add P=L*C, 19-bit unsigned.
  - One multiplier bit of C per cycle, LSB first.
- DIV (exactly 19 cycles):
  - Restoring divide Q=P/D, one quotient bit per cycle, MSB first.
  - Remainder discarded, i.e. truncation.
  - Q<=L always holds, so Q fits 10 bits.
- SPLIT (1 cycle): city_alloc=Q, town_alloc=L-Q, go to DRAW.
- DRAW:
  - draw_valid=1, draw_amount=city_alloc+town_alloc.
  - Hold both until an edge with draw_ready=1, then go to DONE.
  - draw_ready while not in DRAW is ignored.
- DONE (1 cycle): done=1, then IDLE.
- Latency, with E0 = edge sampling start:
  - Non-shortage: draw_valid high after E1.
  - Shortage: draw_valid high after E30 (CALC 1 + MULT 9 + DIV 19 + SPLIT 1).
  - done pulses the cycle after draw_ready is accepted.
- Input sampling: inputs are sampled only at start; later changes do not affect the running cycle.
- Output retention:
  - city_alloc, town_alloc and shortage persist through IDLE until the next accepted start.
  - draw_amount reads 0 outside DRAW.
- Arithmetic: all unsigned.
  - Sum city_alloc+town_alloc never exceeds L.
  - In shortage, city_alloc+town_alloc == L exactly.

Test Plan:
- Reset → start with level=500, city=50, town=30, draw_ready=1:
  - draw_valid high 1 cycle after E1 with draw_amount=80, city_alloc=50, town_alloc=30, shortage=0.
  - done 1 cycle later.
- Shortage: level=400, city=300, town=200:
  - shortage=1; draw_valid rises after E30.
  - city_alloc=240, town_alloc=160, draw_amount=400.
- Truncation: level=100, city=511, town=1:
  - city_alloc=99, town_alloc=1, draw_amount=100, shortage=1.
- Zero demand: city=0, town=0, level=700:
  - no draw_valid ever; done pulses 2 cycles after start; allocations 0.
- Backpressure and start-while-busy:
  - Hold draw_ready=0 for 5 cycles in DRAW: draw_valid/draw_amount remain stable.
  - Pulse start and change inputs during DRAW: both ignored.
  - Release draw_ready: a single done pulse follows.
- Asynchronous reset:
  - Assert reset=0 mid-DIV (cycle 15 after start): outputs 0 immediately, IDLE, no done.
  - A new start after release completes normally.
